fde_controller_verilog: RTL and testbench

FDE_CONTROLLER_VERILOG -- requirements
Module: fde_controller_verilog

---
 rtl/processor_pkg.sv | 35 +++
 rtl/branch_cond_verilog.sv | 27 ++
 rtl/fde_controller_verilog.sv | 130 +++++++++++++
 tb/tb_fde_controller_verilog.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/processor_pkg.sv
// Shared constants for the fetch/decode/execute controller: opcode classes, state
// encodings, branch condition codes and ALU flag bit positions.
package processor_pkg;

  localparam int unsigned DATA_WIDTH = 16;

  localparam logic [3:0] CLASS_ALU = 4'b0001;
  localparam logic [3:0] CLASS_ROM = 4'b0011;
  localparam logic [3:0] CLASS_RAM = 4'b0100;
  localparam logic [3:0] CLASS_PC  = 4'b0111;

  localparam logic [15:0] HALT_WORD = 16'hFFFF;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StFetch   = 3'd1,
    StDecode  = 3'd2,
    StExec    = 3'd3,
    StMemWait = 3'd4,
    StHalt    = 3'd5,
    StFault   = 3'd6
  } state_e;

  localparam logic [3:0] COND_ALWAYS = 4'd0;
  localparam logic [3:0] COND_Z      = 4'd1;
  localparam logic [3:0] COND_NZ     = 4'd2;
  localparam logic [3:0] COND_C      = 4'd3;
  localparam logic [3:0] COND_N      = 4'd4;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_V = 3;

endpackage

// File: rtl/branch_cond_verilog.sv
// Combinational branch condition evaluator: decides whether a PC-class instruction
// takes its branch given the condition code and the current ALU flags.
module branch_cond_verilog
  import processor_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);

  // V is carried on the flag bus but no condition code currently tests it.
  logic unused_v;
  assign unused_v = flags[FLAG_V];

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_ALWAYS: taken = 1'b1;
      COND_Z:      taken = flags[FLAG_Z];
      COND_NZ:     taken = ~flags[FLAG_Z];
      COND_C:      taken = flags[FLAG_C];
      COND_N:      taken = flags[FLAG_N];
      default:     taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/fde_controller_verilog.sv
// Fetch/decode/execute sequencer: latches instruction words, classifies them and drives
// PC, ALU and RAM strobes, with a bounded wait for RAM acknowledge.
module fde_controller_verilog #(
  parameter int unsigned DATA_WIDTH  = processor_pkg::DATA_WIDTH,
  parameter int unsigned RAM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] rom_opcode,
  input  logic [DATA_WIDTH-1:0] rom_operand,
  input  logic [3:0]            alu_flags,
  input  logic                  ram_ack,
  output logic [DATA_WIDTH-1:0] ir_opcode,
  output logic [DATA_WIDTH-1:0] ir_operand,
  output logic                  pc_inc,
  output logic                  pc_load,
  output logic                  alu_en,
  output logic                  ram_req,
  output logic                  ram_we,
  output logic [1:0]            bus_sel,
  output logic [2:0]            state,
  output logic                  halted,
  output logic                  fault,
  output logic [DATA_WIDTH-1:0] instr_count
);
  import processor_pkg::*;

  localparam int unsigned CNT_W = $clog2(RAM_TIMEOUT + 1);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] ir_opcode_q, ir_operand_q, instr_count_q;
  logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
  logic [3:0]            op_class;
  logic                  taken;

  assign op_class = ir_opcode_q[DATA_WIDTH-1 -: 4];

  branch_cond_verilog u_branch_cond (
    .cond  (ir_opcode_q[3:0]),
    .flags (alu_flags),
    .taken (taken)
  );

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    alu_en     = 1'b0;
    ram_req    = 1'b0;
    ram_we     = 1'b0;
    bus_sel    = 2'b00;
    case (state_q)
      StIdle: begin
        if (start) state_d = StFetch;
      end
      StFetch: state_d = StDecode;
      StDecode: begin
        if (ir_opcode_q == DATA_WIDTH'(HALT_WORD)) begin
          state_d = StHalt;
        end else begin
          case (op_class)
            CLASS_ALU, CLASS_ROM, CLASS_PC: state_d = StExec;
            CLASS_RAM:                      state_d = StMemWait;
            default:                        state_d = StFault;
          endcase
        end
      end
      StExec: begin
        state_d = StFetch;
        case (op_class)
          CLASS_ALU: begin
            alu_en  = 1'b1;
            bus_sel = 2'b01;
            pc_inc  = 1'b1;
          end
          CLASS_ROM: pc_inc = 1'b1;
          CLASS_PC: begin
            pc_load = taken;
            pc_inc  = ~taken;
          end
          default: ;
        endcase
      end
      StMemWait: begin
        ram_req = 1'b1;
        bus_sel = 2'b10;
        ram_we  = ir_opcode_q[11];
        // An ack in the last permitted cycle still completes the transfer.
        if (ram_ack) begin
          pc_inc  = 1'b1;
          state_d = StFetch;
        end else if (wait_cnt_q == CNT_W'(RAM_TIMEOUT - 1)) begin
          state_d = StFault;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      StHalt, StFault: ;
      default: state_d = StFault;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      wait_cnt_q    <= '0;
      ir_opcode_q   <= '0;
      ir_operand_q  <= '0;
      instr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (state_q == StFetch) begin
        ir_opcode_q  <= rom_opcode;
        ir_operand_q <= rom_operand;
      end
      if (pc_inc || pc_load) instr_count_q <= instr_count_q + DATA_WIDTH'(1);
    end
  end

  assign ir_opcode   = ir_opcode_q;
  assign ir_operand  = ir_operand_q;
  assign instr_count = instr_count_q;
  assign state       = state_q;
  assign halted      = (state_q == StHalt);
  assign fault       = (state_q == StFault);

endmodule

// File: tb/tb_fde_controller_verilog.sv
// Directed bench for fde_controller_verilog: stimulus pushes expected strobe records,
// a negedge monitor pops and compares them whenever a retire/ALU strobe appears.
module tb_fde_controller_verilog;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
  localparam logic [2:0] S_FAULT  = 3'd6;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] rom_opcode;
  logic [15:0] rom_operand;
  logic [3:0]  alu_flags;
  logic        ram_ack;
  logic [15:0] ir_opcode;
  logic [15:0] ir_operand;
  logic        pc_inc;
  logic        pc_load;
  logic        alu_en;
  logic        ram_req;
  logic        ram_we;
  logic [1:0]  bus_sel;
  logic [2:0]  state;
  logic        halted;
  logic        fault;
  logic [15:0] instr_count;

  typedef struct {
    logic        pc_inc;
    logic        pc_load;
    logic        alu_en;
    logic [1:0]  bus_sel;
    logic        ram_we;
    logic [15:0] count;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [15:0] exp_count;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  fde_controller_verilog u_dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .rom_opcode  (rom_opcode),
    .rom_operand (rom_operand),
    .alu_flags   (alu_flags),
    .ram_ack     (ram_ack),
    .ir_opcode   (ir_opcode),
    .ir_operand  (ir_operand),
    .pc_inc      (pc_inc),
    .pc_load     (pc_load),
    .alu_en      (alu_en),
    .ram_req     (ram_req),
    .ram_we      (ram_we),
    .bus_sel     (bus_sel),
    .state       (state),
    .halted      (halted),
    .fault       (fault),
    .instr_count (instr_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe cycle must match the next queued expectation.
  always @(negedge clk) begin
    if (!reset && (pc_inc || pc_load || alu_en)) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_strobe: got inc=%b ld=%b alu=%b, expected none (t=%0t)",
                 pc_inc, pc_load, alu_en, $time);
      end else begin
        mon_e = sb_q.pop_front();
        check({mon_e.name, ".pc_inc"},  32'(pc_inc),      32'(mon_e.pc_inc));
        check({mon_e.name, ".pc_load"}, 32'(pc_load),     32'(mon_e.pc_load));
        check({mon_e.name, ".alu_en"},  32'(alu_en),      32'(mon_e.alu_en));
        check({mon_e.name, ".bus_sel"}, 32'(bus_sel),     32'(mon_e.bus_sel));
        check({mon_e.name, ".ram_we"},  32'(ram_we),      32'(mon_e.ram_we));
        check({mon_e.name, ".count"},   32'(instr_count), 32'(mon_e.count));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit inc, input bit ld, input bit alu, input logic [1:0] bs,
                      input bit we, input string nm);
    exp_t e;
    e.pc_inc  = inc;
    e.pc_load = ld;
    e.alu_en  = alu;
    e.bus_sel = bs;
    e.ram_we  = we;
    e.count   = exp_count;
    e.name    = nm;
    sb_q.push_back(e);
    exp_count = exp_count + 16'd1;
  endtask

  task automatic do_reset(input string nm);
    reset   = 1'b1;
    start   = 1'b0;
    ram_ack = 1'b0;
    #1;
    check({nm, ".state"},   32'(state),   32'(S_IDLE));
    check({nm, ".ram_req"}, 32'(ram_req), 32'd0);
    tick();
    reset     = 1'b0;
    exp_count = 16'd0;
  endtask

  task automatic start_run(input string nm);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({nm, ".to_fetch"}, 32'(state), 32'(S_FETCH));
  endtask

  // Precondition: state is FETCH. Runs one non-memory instruction through to next FETCH.
  task automatic exec_instr(input logic [15:0] op, input logic [15:0] opnd, input logic [3:0] fl,
                            input bit inc, input bit ld, input bit alu, input logic [1:0] bs,
                            input string nm);
    rom_opcode  = op;
    rom_operand = opnd;
    alu_flags   = fl;
    push(inc, ld, alu, bs, 1'b0, nm);
    tick();
    check({nm, ".decode"},     32'(state),      32'(S_DECODE));
    check({nm, ".ir_opcode"},  32'(ir_opcode),  32'(op));
    check({nm, ".ir_operand"}, 32'(ir_operand), 32'(opnd));
    check({nm, ".dec_quiet"},  32'({pc_inc, pc_load, alu_en, bus_sel}), 32'd0);
    tick();
    check({nm, ".exec"}, 32'(state), 32'(S_EXEC));
    tick();
    check({nm, ".refetch"}, 32'(state),       32'(S_FETCH));
    check({nm, ".count"},   32'(instr_count), 32'(exp_count));
  endtask

  // Precondition: state is FETCH. ack_cycle==0 means never acknowledge.
  task automatic ram_instr(input logic [15:0] op, input int ack_cycle, input int exp_n,
                           input logic [2:0] exp_state, input string nm);
    int n;
    n          = 0;
    rom_opcode = op;
    tick();
    check({nm, ".decode"}, 32'(state), 32'(S_DECODE));
    tick();
    while (state == S_MEM && n < 40) begin
      n++;
      check({nm, ".ram_req"}, 32'(ram_req), 32'd1);
      check({nm, ".ram_we"},  32'(ram_we),  32'(op[11]));
      check({nm, ".bus_sel"}, 32'(bus_sel), 32'd2);
      if (n == ack_cycle) begin
        ram_ack = 1'b1;
        push(1'b1, 1'b0, 1'b0, 2'b10, op[11], {nm, ".ack"});
      end
      tick();
      ram_ack = 1'b0;
    end
    check({nm, ".wait_cycles"}, 32'(n),     32'(exp_n));
    check({nm, ".end_state"},   32'(state), 32'(exp_state));
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    rom_opcode  = 16'h0000;
    rom_operand = 16'h0000;
    alu_flags   = 4'h0;
    ram_ack     = 1'b0;
    exp_count   = 16'd0;
    tick();
    tick();
    check("rst.state",       32'(state),       32'(S_IDLE));
    check("rst.ir_opcode",   32'(ir_opcode),   32'd0);
    check("rst.ir_operand",  32'(ir_operand),  32'd0);
    check("rst.instr_count", 32'(instr_count), 32'd0);
    check("rst.outs", 32'({pc_inc, pc_load, alu_en, ram_req, ram_we, bus_sel, halted, fault}),
          32'd0);
    reset   = 1'b0;
    ram_ack = 1'b1;
    tick();
    tick();
    ram_ack = 1'b0;
    check("rst.release_idle", 32'(state), 32'(S_IDLE));

    start_run("alu");
    exec_instr(16'h1002, 16'h0055, 4'h0, 1'b1, 1'b0, 1'b1, 2'b01, "alu1002");
    check("alu1002.count_is_1", 32'(instr_count), 32'd1);

    exec_instr(16'h7001, 16'h00A0, 4'b0001, 1'b0, 1'b1, 1'b0, 2'b00, "pc_z_taken");
    exec_instr(16'h7001, 16'h00A0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'b00, "pc_z_not");
    exec_instr(16'h7002, 16'h0011, 4'b0000, 1'b0, 1'b1, 1'b0, 2'b00, "pc_nz_taken");
    exec_instr(16'h7003, 16'h0022, 4'b0100, 1'b0, 1'b1, 1'b0, 2'b00, "pc_c_taken");
    exec_instr(16'h7004, 16'h0033, 4'b1101, 1'b1, 1'b0, 1'b0, 2'b00, "pc_n_not");
    exec_instr(16'h700F, 16'h0044, 4'b1111, 1'b1, 1'b0, 1'b0, 2'b00, "pc_never");
    exec_instr(16'h7000, 16'hBEEF, 4'b0000, 1'b0, 1'b1, 1'b0, 2'b00, "pc_always");
    exec_instr(16'h3ABC, 16'h1234, 4'h0,    1'b1, 1'b0, 1'b0, 2'b00, "rom");

    ram_instr(16'h4800, 3, 3, S_FETCH, "ram_wr_ack3");
    check("ram_wr_ack3.count", 32'(instr_count), 32'(exp_count));

    ram_instr(16'h4000, 0, 15, S_FAULT, "ram_timeout");
    check("ram_timeout.fault", 32'(fault), 32'd1);
    do_reset("rst_after_timeout");
    start_run("ram15");
    ram_instr(16'h4000, 15, 15, S_FETCH, "ram_ack15");
    check("ram_ack15.fault", 32'(fault), 32'd0);

    rom_opcode = 16'hFFFF;
    tick();
    tick();
    check("halt.state",  32'(state),  32'(S_HALT));
    check("halt.halted", 32'(halted), 32'd1);
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    check("halt.sticky", 32'(state), 32'(S_HALT));
    do_reset("rst_from_halt");
    check("rst_from_halt.halted", 32'(halted), 32'd0);

    start_run("badop");
    rom_opcode = 16'h2000;
    tick();
    tick();
    check("badop.state", 32'(state), 32'(S_FAULT));
    check("badop.fault", 32'(fault), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("badop.sticky", 32'(state), 32'(S_FAULT));
    do_reset("rst_from_fault");

    start_run("mid_mem");
    rom_opcode = 16'h4800;
    tick();
    tick();
    check("mid_mem.in_wait", 32'(ram_req), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_mem.req_drop", 32'(ram_req), 32'd0);
    check("mid_mem.state",    32'(state),   32'(S_IDLE));
    tick();
    reset     = 1'b0;
    exp_count = 16'd0;
    tick();
    check("mid_mem.stay_idle", 32'(state), 32'(S_IDLE));

    u_dut.instr_count_q = 16'hFFFF;
    exp_count           = 16'hFFFF;
    #1;
    check("wrap.preload", 32'(instr_count), 32'hFFFF);
    start_run("wrap");
    exec_instr(16'h3000, 16'h0000, 4'h0, 1'b1, 1'b0, 1'b0, 2'b00, "wrap_rom");
    check("wrap.zero", 32'(instr_count), 32'd0);

    tick();
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
